// File: rtl/tt_uio_link.sv
// Purpose: byte-serial word link over the 8-bit uio pad bus, with TX/RX FIFOs and a direction FSM that inserts a turnaround cycle.
// Latency: a TX word pushed into an empty FIFO in S_TX shows byte 0 two edges later; an RX word is visible the cycle after its last strobe.
// Backpressure: tx_ready_o drops when the TX FIFO is full; RX words arriving at a full FIFO with no pop are dropped and flagged sticky.
module tt_uio_link #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ena_i,
    input  logic              dir_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    input  logic [7:0]        uio_in_i,
    input  logic              in_strobe_i,
    output logic [7:0]        uio_out_o,
    output logic [7:0]        uio_oe_o,
    output logic              out_strobe_o,
    output logic              overflow_o
);

    localparam int BEATS = DATA_W / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {S_RX, S_TURN, S_TX} state_t;

    state_t            state_q;
    logic [7:0]        uio_oe_q;
    logic [7:0]        uio_out_q;
    logic              out_strobe_q;
    logic              overflow_q;

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] tx_mem_q [DEPTH];
    logic [PW-1:0]     tx_wptr_q, tx_rptr_q;
    logic              tx_full, tx_empty, tx_push, tx_pop;
    logic [DATA_W-1:0] tx_head;

    assign tx_empty   = (tx_wptr_q == tx_rptr_q);
    assign tx_full    = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                        (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    assign tx_ready_o = !tx_full;
    // A pop in the same cycle does not free a slot for a push when full.
    assign tx_push    = tx_valid_i && !tx_full;
    assign tx_head    = tx_mem_q[tx_rptr_q[AW-1:0]];

    // ---------------- TX serializer ----------------
    logic [BW-1:0]     tx_beat_q, tx_beat_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic              tx_start, tx_emit;
    logic [7:0]        tx_byte;

    // Only start a new word while the FSM will stay in S_TX (dir_i still 1),
    // otherwise the word would be cut by the turnaround.
    assign tx_start  = ena_i && (state_q == S_TX) && dir_i &&
                       (tx_beat_q == '0) && !tx_empty;
    assign tx_pop    = tx_start;
    assign tx_emit   = ena_i && ((tx_beat_q != '0) || tx_start);
    assign tx_byte   = tx_start ? tx_head[7:0] : tx_sh_q[7:0];
    assign tx_beat_d = (tx_beat_q == LAST_BEAT) ? '0 : tx_beat_q + BW'(1);
    assign tx_sh_d   = tx_start ? (tx_head >> 8) : (tx_sh_q >> 8);

    // ---------------- RX FIFO ----------------
    logic [DATA_W-1:0] rx_mem_q [DEPTH];
    logic [PW-1:0]     rx_wptr_q, rx_rptr_q;
    logic              rx_full, rx_empty, rx_push, rx_pop, rx_drop;

    assign rx_empty   = (rx_wptr_q == rx_rptr_q);
    assign rx_full    = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                        (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
    assign rx_valid_o = !rx_empty;
    assign rx_data_o  = rx_mem_q[rx_rptr_q[AW-1:0]];
    assign rx_pop     = rx_ready_i && !rx_empty;

    // ---------------- RX deserializer ----------------
    logic [BW-1:0]     rx_beat_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic [DATA_W-1:0] rx_word_d;
    logic              rx_cap, rx_last;

    // No capture on the cycle the FSM leaves S_RX, so no partial word is
    // left behind to corrupt the next reception.
    assign rx_cap  = ena_i && (state_q == S_RX) && in_strobe_i &&
                     !(dir_i && (rx_beat_q == '0));
    assign rx_last = rx_cap && (rx_beat_q == LAST_BEAT);
    // A full FIFO still accepts the word if its head is popped this cycle.
    assign rx_push = rx_last && (!rx_full || rx_pop);
    assign rx_drop = rx_last && rx_full && !rx_pop;

    // Merge the incoming byte into its slot of the assembly register.
    always_comb begin
        rx_word_d = rx_sh_q;
        for (int i = 0; i < BEATS; i++) begin
            if (rx_beat_q == BW'(i)) begin
                rx_word_d[i*8 +: 8] = uio_in_i;
            end
        end
    end

    // FIFO storage: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= tx_data_i;
        if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= rx_word_d;
    end

    // FIFO pointers; user-side push/pop run regardless of ena_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + PW'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PW'(1);
            if (rx_push) rx_wptr_q <= rx_wptr_q + PW'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + PW'(1);
        end
    end

    // Direction FSM with registered pad enables; turns only on word boundaries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_RX;
            uio_oe_q <= 8'h00;
        end else if (ena_i) begin
            case (state_q)
                S_RX: begin
                    if (dir_i && (rx_beat_q == '0)) state_q <= S_TURN;
                end
                S_TURN: begin
                    if (dir_i) begin
                        state_q  <= S_TX;
                        uio_oe_q <= 8'hFF;
                    end else begin
                        state_q  <= S_RX;
                    end
                end
                S_TX: begin
                    if (!dir_i && (tx_beat_q == '0)) begin
                        state_q  <= S_TURN;
                        uio_oe_q <= 8'h00;
                    end
                end
                default: begin
                    state_q  <= S_RX;
                    uio_oe_q <= 8'h00;
                end
            endcase
        end
    end

    // Pin-side serializer: one byte per cycle, strobe frozen while ena_i is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            uio_out_q    <= 8'h00;
            out_strobe_q <= 1'b0;
            tx_beat_q    <= '0;
            tx_sh_q      <= '0;
        end else if (ena_i) begin
            if (tx_emit) begin
                uio_out_q    <= tx_byte;
                out_strobe_q <= 1'b1;
                tx_beat_q    <= tx_beat_d;
                tx_sh_q      <= tx_sh_d;
            end else begin
                out_strobe_q <= 1'b0;
            end
        end
    end

    // Pin-side deserializer and sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_beat_q  <= '0;
            rx_sh_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (rx_cap) begin
                rx_sh_q   <= rx_word_d;
                rx_beat_q <= (rx_beat_q == LAST_BEAT) ? '0 : rx_beat_q + BW'(1);
            end
            if (rx_drop) overflow_q <= 1'b1;
        end
    end

    assign uio_out_o    = uio_out_q;
    assign uio_oe_o     = uio_oe_q;
    assign out_strobe_o = out_strobe_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_tt_uio_link.sv
module tb_tt_uio_link;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int BEATS  = DATA_W / 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              ena_i, dir_i;
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i, tx_ready_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o, rx_ready_i;
    logic [7:0]        uio_in_i;
    logic              in_strobe_i;
    logic [7:0]        uio_out_o, uio_oe_o;
    logic              out_strobe_o, overflow_o;

    tt_uio_link #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ena_i(ena_i), .dir_i(dir_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .uio_in_i(uio_in_i), .in_strobe_i(in_strobe_i),
        .uio_out_o(uio_out_o), .uio_oe_o(uio_oe_o),
        .out_strobe_o(out_strobe_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Scoreboards: expected pad bytes and expected received words, in order.
    logic [7:0]        tx_sb[$];
    logic [DATA_W-1:0] rx_sb[$];
    // Reference model of the RX side: collected bytes, FIFO occupancy, overflow.
    logic [7:0]        part[$];
    int                occ   = 0;
    logic              ovf_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every strobed pad byte and every consumed RX word.
    logic [7:0]        exp_b;
    logic [DATA_W-1:0] exp_w;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (out_strobe_o) begin
                tests++;
                if (tx_sb.size() == 0) begin
                    fails++;
                    $display("FAIL tx_byte: unexpected byte %h oe %h", uio_out_o, uio_oe_o);
                end else begin
                    exp_b = tx_sb.pop_front();
                    if (uio_out_o !== exp_b || uio_oe_o !== 8'hFF) begin
                        fails++;
                        $display("FAIL tx_byte: got %h oe %h expected %h oe ff",
                                 uio_out_o, uio_oe_o, exp_b);
                    end
                end
            end
            if (rx_valid_o && rx_ready_i) begin
                tests++;
                if (rx_sb.size() == 0) begin
                    fails++;
                    $display("FAIL rx_word: unexpected word %h", rx_data_o);
                end else begin
                    exp_w = rx_sb.pop_front();
                    if (rx_data_o !== exp_w) begin
                        fails++;
                        $display("FAIL rx_word: got %h expected %h", rx_data_o, exp_w);
                    end
                end
            end
        end
    end

    // One user-side TX cycle; an accepted word expands to bytes, LSB first.
    task automatic tx_cycle(input logic v, input logic [DATA_W-1:0] d);
        @(posedge clk_i); #1;
        tx_valid_i = v;
        tx_data_i  = d;
        if (v && tx_ready_o) begin
            for (int i = 0; i < BEATS; i++) tx_sb.push_back(d[i*8 +: 8]);
        end
    endtask

    // One pad-side RX cycle with the model applying this cycle's effects.
    task automatic rx_cycle(input logic stb, input logic [7:0] b, input logic rdy);
        logic              pop;
        logic [DATA_W-1:0] w;
        @(posedge clk_i); #1;
        check("rx_valid", {31'b0, rx_valid_o}, {31'b0, occ != 0});
        in_strobe_i = stb;
        uio_in_i    = b;
        rx_ready_i  = rdy;
        pop = rdy && (occ > 0);
        if (stb) begin
            part.push_back(b);
            if (part.size() == BEATS) begin
                w = '0;
                for (int i = 0; i < BEATS; i++) w[i*8 +: 8] = part[i];
                part.delete();
                if (occ - int'(pop) < DEPTH) begin
                    rx_sb.push_back(w);
                    occ++;
                end else begin
                    ovf_m = 1'b1;
                end
            end
        end
        if (pop) occ--;
    endtask

    task automatic wait_tx_drain();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_i);
            if (tx_sb.size() == 0) done = 1;
        end
        check("tx_drain_left", tx_sb.size(), 0);
        tx_sb.delete();
    endtask

    task automatic wait_strobe(input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            if (out_strobe_o) seen = 1;
        end
        check(name, {31'b0, seen}, 1);
    endtask

    int run;

    initial begin
        rst_ni = 1'b0; ena_i = 1'b1; dir_i = 1'b0;
        tx_data_i = '0; tx_valid_i = 1'b0; rx_ready_i = 1'b0;
        uio_in_i = '0; in_strobe_i = 1'b0;
        #23 rst_ni = 1'b1;

        // Reset state
        @(negedge clk_i);
        check("rst_uio_out", uio_out_o, 0);
        check("rst_uio_oe", uio_oe_o, 0);
        check("rst_strobe", out_strobe_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_tx_ready", tx_ready_o, 1);

        // Directed TX of 0xBEEF with latency check
        dir_i = 1'b1;
        repeat (4) @(posedge clk_i);
        tx_cycle(1'b1, 16'hBEEF);
        @(posedge clk_i); #1 tx_valid_i = 1'b0;
        @(negedge clk_i);
        check("tx_lat_idle", out_strobe_o, 0);
        @(negedge clk_i);
        check("tx_b0_strobe", out_strobe_o, 1);
        check("tx_b0_data", uio_out_o, 8'hEF);
        check("tx_b0_oe", uio_oe_o, 8'hFF);
        @(negedge clk_i);
        check("tx_b1_strobe", out_strobe_o, 1);
        check("tx_b1_data", uio_out_o, 8'hBE);
        @(negedge clk_i);
        check("tx_idle_strobe", out_strobe_o, 0);
        check("tx_idle_hold", uio_out_o, 8'hBE);

        // Randomized TX traffic
        for (int i = 0; i < 40; i++) tx_cycle(1'($urandom_range(0, 1)), DATA_W'($urandom));
        tx_cycle(1'b0, '0);
        wait_tx_drain();

        // Deferred turnaround: direction drops after byte 0
        tx_cycle(1'b1, DATA_W'($urandom));
        tx_cycle(1'b0, '0);
        wait_strobe("defer_b0_seen");
        dir_i = 1'b0;
        @(negedge clk_i);
        check("defer_b1_strobe", out_strobe_o, 1);
        check("defer_b1_oe", uio_oe_o, 8'hFF);
        @(negedge clk_i);
        check("defer_turn_strobe", out_strobe_o, 0);
        check("defer_turn_oe", uio_oe_o, 8'h00);
        repeat (2) @(posedge clk_i);
        check("defer_rx_oe", uio_oe_o, 8'h00);

        // Directed RX assembly of 0x1234
        rx_cycle(1'b1, 8'h34, 1'b0);
        rx_cycle(1'b1, 8'h12, 1'b0);
        rx_cycle(1'b0, 8'h00, 1'b0);
        check("rx_1234_data", rx_data_o, 16'h1234);
        rx_cycle(1'b0, 8'h00, 1'b1);
        rx_cycle(1'b0, 8'h00, 1'b0);

        // Overflow: DEPTH+1 words with no consumer
        for (int w = 0; w <= DEPTH; w++)
            for (int b = 0; b < BEATS; b++) rx_cycle(1'b1, 8'($urandom), 1'b0);
        rx_cycle(1'b0, 8'h00, 1'b0);
        check("ovf_set", overflow_o, ovf_m);
        check("ovf_model", ovf_m, 1);
        repeat (DEPTH + 1) rx_cycle(1'b0, 8'h00, 1'b1);
        rx_cycle(1'b0, 8'h00, 1'b0);
        check("ovf_drained", rx_sb.size(), 0);
        check("ovf_sticky", overflow_o, 1);

        // Randomized RX traffic with random consumer backpressure
        for (int i = 0; i < 80; i++)
            rx_cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
        while (part.size() != 0) rx_cycle(1'b1, 8'($urandom), 1'b1);
        repeat (DEPTH + 2) rx_cycle(1'b0, 8'h00, 1'b1);
        rx_cycle(1'b0, 8'h00, 1'b0);
        check("rx_rand_drained", rx_sb.size(), 0);
        check("rx_rand_ovf", overflow_o, ovf_m);

        // TX full while frozen, then back-to-back release
        dir_i = 1'b1;
        repeat (4) @(posedge clk_i);
        @(posedge clk_i); #1 ena_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check("tx_fill_ready", tx_ready_o, 1);
            tx_valid_i = 1'b1;
            tx_data_i  = DATA_W'($urandom);
            for (int b = 0; b < BEATS; b++) tx_sb.push_back(tx_data_i[b*8 +: 8]);
            @(posedge clk_i); #1;
        end
        check("tx_full_ready", tx_ready_o, 0);
        tx_data_i = DATA_W'($urandom);
        @(posedge clk_i); #1;
        tx_valid_i = 1'b0;
        check("tx_refused_ready", tx_ready_o, 0);
        check("tx_frozen_strobe", out_strobe_o, 0);
        ena_i = 1'b1;
        wait_strobe("b2b_start");
        run = 1;
        for (int i = 0; i < 4 * DEPTH && out_strobe_o; i++) begin
            @(negedge clk_i);
            if (out_strobe_o) run++;
        end
        check("b2b_run_len", run, 2 * DEPTH);
        wait_tx_drain();

        // Async reset in the middle of a TX word
        for (int i = 0; i < 3; i++) tx_cycle(1'b1, DATA_W'($urandom));
        tx_cycle(1'b0, '0);
        wait_strobe("mid_rst_seen");
        #1 rst_ni = 1'b0;
        #1;
        check("arst_uio_out", uio_out_o, 0);
        check("arst_oe", uio_oe_o, 0);
        check("arst_strobe", out_strobe_o, 0);
        check("arst_overflow", overflow_o, 0);
        tx_sb.delete(); rx_sb.delete(); part.delete(); occ = 0; ovf_m = 1'b0;
        #10 rst_ni = 1'b1;
        repeat (12) @(negedge clk_i);
        check("post_rst_ready", tx_ready_o, 1);
        check("post_rst_strobe", out_strobe_o, 0);
        check("post_rst_rx_valid", rx_valid_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
